agex_muldiv_seq: RTL and testbench
==================================

Name: agex_muldiv_seq

Overview:
Iterative multiply/divide sequencer attached to the AGEX stage. It accepts one RV32M-style unsigned op from AGEX and runs a 1-bit-per-cycle shift-add multiply or restoring divide. While it runs, it stalls FE/DE and freezes the AGEX latch. It returns the result to AGEX on a one-cycle done pulse, and the normal AGEX latch update captures that result.

Parameters:
DBITS, 32, operand/result width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DBITS

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
start_i  input  1  AGEX holds a valid muldiv op
op_i  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
src1_i  input  DBITS  rs1 value / dividend / multiplicand
src2_i  input  DBITS  rs2 value / divisor / multiplier
flush_i  input  1  branch redirect from AGEX; kills the in-flight op
stall_o  output  1  hold FE/DE latches and AGEX latch
busy_o  output  1  FSM not in IDLE
done_o  output  1  result valid this cycle (one-cycle pulse)
result_o  output  DBITS  op result; 0 when done_o=0

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state:
  - State = IDLE.
  - All internal registers cleared.
  - stall_o=0, busy_o=0, done_o=0, result_o=0.
- Reset asserted mid-operation aborts the op. No done_o is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 and flush_i=0: latch op_i, src1_i and src2_i; clear the counter; go to RUN.
  - stall_o = start_i & ~flush_i (combinational), so AGEX holds the instruction in the same cycle.
  - If start_i=1 and flush_i=1 together, flush wins and the op is not started.
- RUN:
  - stall_o=1. The counter increments every cycle.
  - MUL/MULHU: 2*DBITS-bit accumulator. Each cycle, if multiplier bit 0 is 1, add the shifted multiplicand. Then shift the multiplicand left and the multiplier right.
  - DIVU/REMU: restoring division. Shift the remainder left and bring in the next dividend MSB. If remainder >= divisor, subtract and set the quotient bit.
  - After DBITS iterations (counter == DBITS-1 in the last RUN cycle), go to DONE.
  - flush_i=1 in RUN: go to IDLE next cycle. No done_o. stall_o drops in the cycle after the flush.
- DONE:
  - done_o=1, stall_o=0. result_o is selected by op:
    - MUL: acc[DBITS-1:0]
    - MULHU: acc[2*DBITS-1:DBITS]
    - DIVU: quotient
    - REMU: remainder
  - Always returns to IDLE next cycle. start_i and flush_i are ignored in DONE; the AGEX latch advances this cycle.
- Latency: start accepted at cycle T gives done_o at T+DBITS+1. stall_o is high during cycles T..T+DBITS.
- Divide by zero needs no special case: the restoring algorithm yields quotient = all ones and remainder = src1.
- All arithmetic is unsigned, with no sign extension. Operands are sampled only at accept; later changes on src*_i are ignored.
- Back-to-back ops: the next start is accepted at the earliest in the IDLE cycle after DONE.

Optional Feature:
MULDIV_EARLY_OUT_EN
- When defined, the IDLE-accept cycle checks for trivial cases and goes directly to DONE (done_o at T+1, stall_o high only in cycle T):
  - MUL/MULHU with src1_i==0 or src2_i==0: result 0.
  - DIVU/REMU with src1_i < src2_i (unsigned): quotient 0, remainder src1_i.
- When not defined, these cases take the full DBITS+1 latency.
- Results are identical with and without the macro.

Test Plan:
- MUL src1=7, src2=6 -> stall_o high for 33 cycles, done_o pulse at T+33, result_o=42.
- MULHU src1=0xFFFFFFFF, src2=0x2 -> result_o=0x00000001; the same operands with MUL -> result_o=0xFFFFFFFE.
- DIVU 100/7 -> result_o=14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- DIVU 100/7 started, flush_i=1 at T+10 -> state returns to IDLE, stall_o=0 from T+11, no done_o; a new REMU 9/4 then gives result_o=1.
- start_i and flush_i both high in IDLE -> no accept, stall_o=0, busy_o=0. reset asserted at T+5 of a MUL -> all outputs 0 next cycle, no done_o.
- With MULDIV_EARLY_OUT_EN: DIVU 3/10 -> done_o at T+1, result_o=0; MUL 0*123 -> done_o at T+1, result_o=0. Without the macro, the same ops complete at T+33 with the same results.

Source files
------------

// File: rtl/agex_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer beside AGEX; stalls the front end while running.
// Optional MULDIV_EARLY_OUT_EN: trivial operands skip straight from accept to DONE.
module agex_muldiv_seq #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [DBITS-1:0] src1_i,
    input  logic [DBITS-1:0] src2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [DBITS-1:0] result_o
);

    localparam int unsigned AW = 2 * DBITS;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DBITS - 1);
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    acc_q, acc_d;      // MUL: product; DIV: {remainder, quotient/dividend}
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [DBITS-1:0] b_q, b_d;          // multiplier or divisor
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DBITS:0]   rem_sh;
    logic             trivial;

    // Partial remainder shifted left with the next dividend bit, plus early-out detect
    always_comb begin
        rem_sh  = {acc_q[AW-1:DBITS], acc_q[DBITS-1]};
        trivial = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        if (op_i[1]) begin
            trivial = (src1_i < src2_i);
        end else begin
            trivial = (src1_i == '0) || (src2_i == '0);
        end
`endif
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        stall_o  = 1'b0;
        busy_o   = (state_q != IDLE);
        done_o   = 1'b0;
        result_o = '0;

        case (state_q)
            IDLE: begin
                stall_o = start_i & ~flush_i;
                if (start_i && !flush_i) begin
                    op_d    = op_i;
                    b_d     = src2_i;
                    cnt_d   = '0;
                    mcand_d = {{DBITS{1'b0}}, src1_i};
                    acc_d   = op_i[1] ? {{DBITS{1'b0}}, src1_i} : '0;
                    state_d = RUN;
                    if (trivial) begin
                        // Trivial cases: product 0, or quotient 0 with remainder = dividend
                        acc_d   = op_i[1] ? {src1_i, {DBITS{1'b0}}} : '0;
                        state_d = DONE;
                    end
                end
            end

            RUN: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (op_q[1]) begin
                    if (rem_sh >= {1'b0, b_q}) begin
                        acc_d[AW-1:DBITS] = DBITS'(rem_sh - {1'b0, b_q});
                        acc_d[DBITS-1:0]  = {acc_q[DBITS-2:0], 1'b1};
                    end else begin
                        acc_d[AW-1:DBITS] = rem_sh[DBITS-1:0];
                        acc_d[DBITS-1:0]  = {acc_q[DBITS-2:0], 1'b0};
                    end
                end else begin
                    if (b_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                end
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
                case (op_q)
                    OP_MUL:   result_o = acc_q[DBITS-1:0];
                    OP_MULHU: result_o = acc_q[AW-1:DBITS];
                    OP_DIVU:  result_o = acc_q[DBITS-1:0];
                    default:  result_o = acc_q[AW-1:DBITS];
                endcase
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_agex_muldiv_seq.sv
// Randomized self-checking bench for agex_muldiv_seq against a plain-arithmetic reference.
module tb_agex_muldiv_seq;

    localparam int unsigned DBITS = 32;
    localparam int unsigned CNT_W = 6;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start_i;
    logic [1:0]       op_i;
    logic [DBITS-1:0] src1_i;
    logic [DBITS-1:0] src2_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [DBITS-1:0] result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    agex_muldiv_seq #(.DBITS(DBITS), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .op_i     (op_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit triv;
        triv = op[1] ? (a < b) : ((a == 0) || (b == 0));
        return (EARLY && triv) ? 1 : DBITS + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current (IDLE) cycle and follow it to its done pulse
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int k;
        int stall_bad;
        logic [31:0] exp_res;
        exp_res   = ref_result(op, a, b);
        start_i   = 1'b1;
        op_i      = op;
        src1_i    = a;
        src2_i    = b;
        #1;
        check({tag, "_stall_accept"}, 64'(stall_o), 64'd1);
        tick();
        start_i   = 1'b0;
        op_i      = 2'($urandom);
        src1_i    = $urandom;
        src2_i    = $urandom;
        k         = 1;
        stall_bad = 0;
        while (!done_o && k < 100) begin
            if (!stall_o || !busy_o || result_o != 0) stall_bad++;
            tick();
            k++;
        end
        check({tag, "_run_stall"}, 64'(stall_bad), 64'd0);
        check({tag, "_latency"}, 64'(k), 64'(ref_latency(op, a, b)));
        check({tag, "_result"}, 64'(result_o), 64'(exp_res));
        check({tag, "_done_stall"}, 64'(stall_o), 64'd0);
        tick();
        check({tag, "_after"}, {61'd0, done_o, busy_o, stall_o}, 64'd0);
    endtask

    initial begin
        int dones;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int mode;

        reset   = 1'b1;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        src1_i  = '0;
        src2_i  = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_outs", {28'd0, result_o, done_o, busy_o, stall_o}, 64'd0);
        tick();

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6);
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'd2);
        run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'd2);
        run_op("divu_100_7", 2'd2, 32'd100, 32'd7);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
        run_op("divu_5_0", 2'd2, 32'd5, 32'd0);
        run_op("remu_5_0", 2'd3, 32'd5, 32'd0);
        run_op("divu_3_10", 2'd2, 32'd3, 32'd10);
        run_op("mul_0x123", 2'd0, 32'd0, 32'd123);

        // Flush at T+10 of a divide: no done, stall gone at T+11
        start_i = 1'b1; op_i = 2'd2; src1_i = 32'd100; src2_i = 32'd7;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_outs", {61'd0, done_o, busy_o, stall_o}, 64'd0);
        dones = 0;
        repeat (40) begin
            tick();
            if (done_o) dones++;
        end
        check("flush_no_done", 64'(dones), 64'd0);
        run_op("remu_9_4", 2'd3, 32'd9, 32'd4);

        // Start and flush together in IDLE
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'd0; src1_i = 32'd3; src2_i = 32'd3;
        #1;
        check("sf_stall", 64'(stall_o), 64'd0);
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        check("sf_idle", {61'd0, done_o, busy_o, stall_o}, 64'd0);
        tick();

        // Reset at T+5 of a multiply
        start_i = 1'b1; op_i = 2'd0; src1_i = 32'd7; src2_i = 32'd6;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_outs", {28'd0, result_o, done_o, busy_o, stall_o}, 64'd0);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            tick();
            if (done_o) dones++;
        end
        check("rst_no_done", 64'(dones), 64'd0);

        for (int i = 0; i < 24; i++) begin
            rop  = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 3);
            ra   = $urandom;
            rb   = $urandom;
            case (mode)
                1: begin ra = $urandom_range(0, 255); rb = $urandom_range(0, 15); end
                2: begin if ($urandom_range(0, 1) == 1) ra = 0; else rb = 0; end
                3: begin ra = $urandom_range(0, 1000); rb = ra + 32'($urandom_range(1, 1000)); end
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
